halt_dump_ctrl: RTL

- Synthesisable run-control and memory-dump unit for the pipelined MIPS core.
- Watches the retire (write-back) stage for the halt instruction and asserts a stop to the core.
- After a halt, or if a cycle budget runs out, it reads a parametrised window of data RAM and streams each word out over a valid/ready interface.
- Also provides cycle and retired-instruction counters for end-of-run reporting.

---
 rtl/halt_dump_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/halt_dump_ctrl.sv
// Run-control and memory-dump unit: stops the core on a retired halt (or when the
// cycle budget runs out), then streams a window of data RAM out over valid/ready.
module halt_dump_ctrl #(
    parameter int unsigned         INSTR_W      = 32,
    parameter int unsigned         DATA_W       = 32,
    parameter int unsigned         ADDR_W       = 9,
    parameter int unsigned         BASE_ADDR    = 0,
    parameter int unsigned         DUMP_DEPTH   = 512,
    parameter logic [INSTR_W-1:0]  HALT_PATTERN = {INSTR_W{1'b1}},
    parameter int unsigned         TIMEOUT      = 65535,
    parameter int unsigned         CNT_W        = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                retire_valid,
    input  logic [INSTR_W-1:0]  retire_instr,
    output logic                stop,
    output logic                mem_rd_en,
    output logic [ADDR_W-1:0]   mem_rd_addr,
    input  logic [DATA_W-1:0]   mem_rd_data,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [DATA_W-1:0]   dump_data,
    output logic [ADDR_W-1:0]   dump_addr,
    output logic                dump_last,
    output logic                done,
    output logic                timed_out,
    output logic [CNT_W-1:0]    cycle_count,
    output logic [CNT_W-1:0]    retired_count
);

    localparam logic [2:0] S_RUN  = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DUMP_DEPTH - 1);
    localparam bit                TO_EN      = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0]  TO_LAST    = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    logic [2:0]         state_q,  state_d;
    logic [ADDR_W-1:0]  ptr_q,    ptr_d;
    logic               stop_q,   stop_d;
    logic               rd_en_q,  rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               valid_q,  valid_d;
    logic [DATA_W-1:0]  data_q,   data_d;
    logic [ADDR_W-1:0]  addr_q,   addr_d;
    logic               last_q,   last_d;
    logic               done_q,   done_d;
    logic               to_q,     to_d;
    logic [CNT_W-1:0]   cyc_q,    cyc_d;
    logic [CNT_W-1:0]   ret_q,    ret_d;
    logic               halt_hit;

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        stop_d    = stop_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        addr_d    = addr_q;
        last_d    = last_q;
        done_d    = done_q;
        to_d      = to_q;
        cyc_d     = cyc_q;
        ret_d     = ret_q;
        halt_hit  = retire_valid && (retire_instr == HALT_PATTERN);

        case (state_q)
            S_RUN: begin
                if (cyc_q != CNT_MAX) cyc_d = cyc_q + CNT_W'(1);
                if (retire_valid && (ret_q != CNT_MAX)) ret_d = ret_q + CNT_W'(1);
                // Halt takes priority over a simultaneous timeout.
                if (halt_hit || (TO_EN && (cyc_q == TO_LAST))) begin
                    state_d   = S_RD;
                    stop_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = ptr_q;
                    to_d      = !halt_hit;
                end
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                data_d  = mem_rd_data;
                addr_d  = ptr_q;
                last_d  = (ptr_q == LAST_ADDR);
                valid_d = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ptr_d     = ptr_q + ADDR_W'(1);
                        rd_en_d   = 1'b1;
                        rd_addr_d = ptr_q + ADDR_W'(1);
                        state_d   = S_RD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_RUN;
            ptr_q     <= FIRST_ADDR;
            stop_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            addr_q    <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            to_q      <= 1'b0;
            cyc_q     <= '0;
            ret_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            stop_q    <= stop_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            addr_q    <= addr_d;
            last_q    <= last_d;
            done_q    <= done_d;
            to_q      <= to_d;
            cyc_q     <= cyc_d;
            ret_q     <= ret_d;
        end
    end

    assign stop          = stop_q;
    assign mem_rd_en     = rd_en_q;
    assign mem_rd_addr   = rd_addr_q;
    assign dump_valid    = valid_q;
    assign dump_data     = data_q;
    assign dump_addr     = addr_q;
    assign dump_last     = last_q;
    assign done          = done_q;
    assign timed_out     = to_q;
    assign cycle_count   = cyc_q;
    assign retired_count = ret_q;

endmodule
